// File: rtl/imm_decode_pipe.sv
// Registered RV32I/RV64I immediate generator with opcode classification.
// Output register plus one skid entry keeps a full beat per cycle under stall.
module imm_decode_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam bit RV64 = (XLEN == 64);

    localparam logic [2:0] F_R   = 3'd0;
    localparam logic [2:0] F_I   = 3'd1;
    localparam logic [2:0] F_S   = 3'd2;
    localparam logic [2:0] F_B   = 3'd3;
    localparam logic [2:0] F_U   = 3'd4;
    localparam logic [2:0] F_J   = 3'd5;
    localparam logic [2:0] F_SH  = 3'd6;
    localparam logic [2:0] F_ILL = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OPIM32 = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic [TAG_W-1:0] tag;
    } beat_t;

    logic [6:0] op;
    logic [2:0] f3;
    logic       sh;
    logic       is_i, is_opi, is_opi32, is_s, is_b, is_u, is_j, is_r;

    assign op = in_instr[6:0];
    assign f3 = in_instr[14:12];
    assign sh = (f3 == 3'b001) || (f3 == 3'b101);

    assign is_i     = (op == OP_LOAD) || (op == OP_JALR);
    assign is_opi   = (op == OP_OPIMM);
    assign is_opi32 = RV64 && (op == OP_OPIM32);
    assign is_s     = (op == OP_STORE);
    assign is_b     = (op == OP_BRANCH);
    assign is_u     = (op == OP_LUI) || (op == OP_AUIPC);
    assign is_j     = (op == OP_JAL);
    assign is_r     = (op == OP_OP) || (RV64 && (op == OP_OP32));

    logic [11:0] raw_i, raw_s;
    logic [12:0] raw_b;
    logic [31:0] raw_u;
    logic [20:0] raw_j;

    assign raw_i = in_instr[31:20];
    assign raw_s = {in_instr[31:25], in_instr[11:7]};
    assign raw_b = {in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
    assign raw_u = {in_instr[31:12], 12'b0};
    assign raw_j = {in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

    logic [XLEN-1:0] imm_i, shamt;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;

    assign imm_i = XLEN'($signed(raw_i));
    assign shamt = RV64 ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);

    // Any encoding not claimed below falls through as ILLEGAL with imm=0.
    always_comb begin
        dec_imm = '0;
        dec_fmt = F_ILL;
        unique case (1'b1)
            is_i: begin
                dec_imm = imm_i;
                dec_fmt = F_I;
            end
            is_opi: begin
                if (!sh) begin
                    dec_imm = imm_i;
                    dec_fmt = F_I;
                end else if (RV64 || !in_instr[25]) begin
                    dec_imm = shamt;
                    dec_fmt = F_SH;
                end
            end
            is_opi32: begin
                if (!sh) begin
                    dec_imm = imm_i;
                    dec_fmt = F_I;
                end else if (!in_instr[25]) begin
                    dec_imm = XLEN'(in_instr[24:20]);
                    dec_fmt = F_SH;
                end
            end
            is_s: begin
                dec_imm = XLEN'($signed(raw_s));
                dec_fmt = F_S;
            end
            is_b: begin
                dec_imm = XLEN'($signed(raw_b));
                dec_fmt = F_B;
            end
            is_u: begin
                dec_imm = XLEN'($signed(raw_u));
                dec_fmt = F_U;
            end
            is_j: begin
                dec_imm = XLEN'($signed(raw_j));
                dec_fmt = F_J;
            end
            is_r: begin
                dec_fmt = F_R;
            end
            default: ;
        endcase
    end

    beat_t new_beat, out_q, skid_q;
    logic  out_full, skid_full;
    logic  accept, drain;

    assign new_beat = '{imm: dec_imm, fmt: dec_fmt, tag: in_tag};
    assign in_ready = !skid_full;
    assign accept   = in_valid && in_ready;
    assign drain    = out_full && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            skid_q    <= '0;
            out_full  <= 1'b0;
            skid_full <= 1'b0;
        end else if (skid_full) begin
            if (drain) begin
                out_q     <= skid_q;
                skid_full <= 1'b0;
            end
        end else if (accept) begin
            if (!out_full || out_ready) begin
                out_q    <= new_beat;
                out_full <= 1'b1;
            end else begin
                skid_q    <= new_beat;
                skid_full <= 1'b1;
            end
        end else if (drain) begin
            out_full <= 1'b0;
        end
    end

    // Counted at accept time so stalls downstream do not delay the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (cnt_clr) begin
            illegal_cnt <= '0;
        end else if (accept && (dec_fmt == F_ILL) && !(&illegal_cnt)) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

    assign out_valid   = out_full;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_illegal = (out_q.fmt == F_ILL);
    assign out_tag     = out_q.tag;

endmodule
